// File: rtl/mc_ctrl_pkg.sv
// ============================================================================
// Module  : mc_ctrl_pkg
// Brief   : Shared opcode/funct constants, state and instruction-class types
//           for the multi-cycle control unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;

    localparam logic [1:0] TRAP_NONE    = 2'd0;
    localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
    localparam logic [1:0] TRAP_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        CLS_R    = 4'd0,
        CLS_ADDI = 4'd1,
        CLS_ANDI = 4'd2,
        CLS_ORI  = 4'd3,
        CLS_LW   = 4'd4,
        CLS_SW   = 4'd5,
        CLS_BEQ  = 4'd6,
        CLS_BNE  = 4'd7,
        CLS_J    = 4'd8
    } cls_t;

    // Control-flow instructions finish in EXEC and never reach MEM/WB.
    function automatic logic cls_retires_in_exec(input cls_t c);
        return (c == CLS_BEQ) || (c == CLS_BNE) || (c == CLS_J);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
// ============================================================================
// Module  : mc_ctrl_decode
// Brief   : Combinational opcode to instruction-class decoder with illegal flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_ctrl_decode
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] opcode,
    output cls_t            cls,
    output logic            illegal
);

    always_comb begin
        cls     = CLS_R;
        illegal = 1'b0;
        case (opcode)
            OP_W'(OP_RTYPE): cls = CLS_R;
            OP_W'(OP_ADDI):  cls = CLS_ADDI;
            OP_W'(OP_ANDI):  cls = CLS_ANDI;
            OP_W'(OP_ORI):   cls = CLS_ORI;
            OP_W'(OP_LW):    cls = CLS_LW;
            OP_W'(OP_SW):    cls = CLS_SW;
            OP_W'(OP_BEQ):   cls = CLS_BEQ;
            OP_W'(OP_BNE):   cls = CLS_BNE;
            OP_W'(OP_J):     cls = CLS_J;
            default:         illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mc_ctrl.sv
// ============================================================================
// Module  : mc_ctrl
// Brief   : Multi-cycle controller sequencing FETCH/DECODE/EXEC/MEM/WB with a
//           memory handshake, illegal-opcode and timeout traps, retire counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W        = 6,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [OP_W-1:0]  opcode,
    input  logic [OP_W-1:0]  funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic             write,
    output logic [OP_W-1:0]  alu_funct,
    output logic             rd_mux_s,
    output logic             op2_mux_s,
    output logic             branch_mux_s,
    output logic             wb_mux_s,
    output logic             trap,
    output logic [1:0]       trap_code,
    output logic [CNT_W-1:0] retired
);

    localparam int              TMO_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_t             r_state;
    cls_t               r_cls;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_trap;
    logic [1:0]         r_trap_code;
    logic [CNT_W-1:0]   r_retired;

    cls_t               w_cls;
    logic               w_illegal;
    logic               w_waiting;
    logic               w_expire;
    logic               w_taken;
    logic               w_retire;
    logic               w_active;

    mc_ctrl_decode #(
        .OP_W    (OP_W)
    ) u_decode (
        .opcode  (opcode),
        .cls     (w_cls),
        .illegal (w_illegal)
    );

    assign w_waiting = (r_state == ST_FETCH) || (r_state == ST_MEM);
    // mem_ready arriving on the final allowed cycle wins over the timeout.
    assign w_expire  = w_waiting && !mem_ready && (r_tmo == TMO_LAST);
    assign w_taken   = (r_cls == CLS_J) ||
                       ((r_cls == CLS_BEQ) && zero) ||
                       ((r_cls == CLS_BNE) && !zero);
    assign w_retire  = ((r_state == ST_EXEC) && cls_retires_in_exec(r_cls)) ||
                       ((r_state == ST_MEM) && mem_ready && (r_cls == CLS_SW)) ||
                       (r_state == ST_WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cls       <= CLS_R;
            r_tmo       <= '0;
            r_trap      <= 1'b0;
            r_trap_code <= TRAP_NONE;
            r_retired   <= '0;
        end else begin
            // Wait counter only survives while stalling in FETCH/MEM.
            r_tmo <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (!load) begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (mem_ready) begin
                        r_state <= ST_DECODE;
                    end else if (w_expire) begin
                        r_state     <= ST_TRAP;
                        r_trap      <= 1'b1;
                        r_trap_code <= TRAP_TIMEOUT;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                ST_DECODE: begin
                    r_cls <= w_cls;
                    if (w_illegal) begin
                        r_state     <= ST_TRAP;
                        r_trap      <= 1'b1;
                        r_trap_code <= TRAP_ILLEGAL;
                    end else begin
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cls_retires_in_exec(r_cls)) begin
                        r_state <= load ? ST_IDLE : ST_FETCH;
                    end else if ((r_cls == CLS_LW) || (r_cls == CLS_SW)) begin
                        r_state <= ST_MEM;
                    end else begin
                        r_state <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        if (r_cls == CLS_SW) begin
                            r_state <= load ? ST_IDLE : ST_FETCH;
                        end else begin
                            r_state <= ST_WB;
                        end
                    end else if (w_expire) begin
                        r_state     <= ST_TRAP;
                        r_trap      <= 1'b1;
                        r_trap_code <= TRAP_TIMEOUT;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                ST_WB: begin
                    r_state <= load ? ST_IDLE : ST_FETCH;
                end
                ST_TRAP: begin
                    r_state <= ST_TRAP;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    // ALU/mux selects stay valid through MEM and WB so the datapath result is stable.
    assign w_active = (r_state == ST_EXEC) || (r_state == ST_MEM) || (r_state == ST_WB);

    always_comb begin
        alu_funct = '0;
        rd_mux_s  = 1'b0;
        op2_mux_s = 1'b0;
        if (w_active) begin
            case (r_cls)
                CLS_R: begin
                    alu_funct = funct;
                    rd_mux_s  = 1'b1;
                end
                CLS_ADDI, CLS_LW, CLS_SW: begin
                    alu_funct = OP_W'(F_ADD);
                    op2_mux_s = 1'b1;
                end
                CLS_ANDI: begin
                    alu_funct = OP_W'(F_AND);
                    op2_mux_s = 1'b1;
                end
                CLS_ORI: begin
                    alu_funct = OP_W'(F_OR);
                    op2_mux_s = 1'b1;
                end
                CLS_BEQ, CLS_BNE: begin
                    alu_funct = OP_W'(F_SUB);
                end
                default: begin
                    alu_funct = '0;
                end
            endcase
        end
    end

    always_comb begin
        mem_req      = w_waiting;
        mem_we       = (r_state == ST_MEM) && (r_cls == CLS_SW);
        ir_write     = (r_state == ST_FETCH) && mem_ready;
        pc_write     = ((r_state == ST_FETCH) && mem_ready) ||
                       ((r_state == ST_EXEC) && w_taken);
        branch_mux_s = (r_state == ST_EXEC) && w_taken;
        write        = (r_state == ST_WB);
        wb_mux_s     = (r_state == ST_WB) && (r_cls == CLS_LW);
    end

    assign trap      = r_trap;
    assign trap_code = r_trap_code;
    assign retired   = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl.sv
// ============================================================================
// Module  : tb_mc_ctrl
// Brief   : Self-checking bench for mc_ctrl with an instruction-level model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_ctrl;

    localparam int OP_W  = 6;
    localparam int CNT_W = 4;
    localparam int TMO   = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             load;
    logic [OP_W-1:0]  opcode;
    logic [OP_W-1:0]  funct;
    logic             zero;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             ir_write;
    logic             pc_write;
    logic             write;
    logic [OP_W-1:0]  alu_funct;
    logic             rd_mux_s;
    logic             op2_mux_s;
    logic             branch_mux_s;
    logic             wb_mux_s;
    logic             trap;
    logic [1:0]       trap_code;
    logic [CNT_W-1:0] retired;

    int errors  = 0;
    int checks  = 0;
    int exp_ret = 0;

    logic [21:0] all_outs;
    assign all_outs = {mem_req, mem_we, ir_write, pc_write, write, alu_funct, rd_mux_s,
                       op2_mux_s, branch_mux_s, wb_mux_s, trap, trap_code, retired};

    logic [5:0] legal_ops [9] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};

    always #5 clk = ~clk;

    mc_ctrl #(
        .OP_W         (OP_W),
        .CNT_W        (CNT_W),
        .MEM_TIMEOUT  (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load),
        .opcode       (opcode),
        .funct        (funct),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .write        (write),
        .alu_funct    (alu_funct),
        .rd_mux_s     (rd_mux_s),
        .op2_mux_s    (op2_mux_s),
        .branch_mux_s (branch_mux_s),
        .wb_mux_s     (wb_mux_s),
        .trap         (trap),
        .trap_code    (trap_code),
        .retired      (retired)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    function automatic logic [5:0] exp_alu(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00:               return fn;
            6'h08, 6'h23, 6'h2B: return 6'h20;
            6'h0C:               return 6'h24;
            6'h0D:               return 6'h25;
            6'h04, 6'h05:        return 6'h22;
            default:             return 6'h00;
        endcase
    endfunction

    // One instruction end to end; entered at the start of a FETCH cycle.
    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int fw, input int mw, input logic ld);
        bit legal  = 1'b0;
        bit is_mem = (op == 6'h23) || (op == 6'h2B);
        bit is_ctl = (op == 6'h04) || (op == 6'h05) || (op == 6'h02);
        bit taken  = (op == 6'h02) || (op == 6'h04 && z) || (op == 6'h05 && !z);
        foreach (legal_ops[i]) if (legal_ops[i] == op) legal = 1'b1;

        for (int k = 1; k <= fw; k++) begin
            mem_ready = (k == fw);
            opcode    = 6'($urandom);
            funct     = 6'($urandom);
            settle();
            check("fetch_mem_req", mem_req, 1);
            check("fetch_ir_write", ir_write, k == fw);
            check("fetch_pc_write", pc_write, k == fw);
            tick();
        end
        opcode    = op;
        funct     = fn;
        mem_ready = 1'($urandom);
        settle();
        check("decode_quiet", {mem_req, write, pc_write, ir_write}, 0);
        tick();
        if (!legal) begin
            mem_ready = 1'b0;
            settle();
            check("illegal_trap", {trap, trap_code}, 3'b101);
            check("illegal_mem_req", mem_req, 0);
            return;
        end

        load      = ld;
        zero      = z;
        mem_ready = 1'($urandom);
        settle();
        if (op != 6'h02) check("exec_alu_funct", alu_funct, exp_alu(op, fn));
        check("exec_rd_mux", rd_mux_s, op == 6'h00);
        if (!is_ctl) check("exec_op2_mux", op2_mux_s, op != 6'h00);
        check("exec_pc_write", pc_write, taken);
        check("exec_branch_mux", branch_mux_s, taken);
        check("exec_quiet", {write, mem_req, ir_write}, 0);
        tick();

        if (is_mem) begin
            for (int k = 1; k <= mw; k++) begin
                mem_ready = (k == mw);
                zero      = 1'($urandom);
                settle();
                check("mem_req", mem_req, 1);
                check("mem_we", mem_we, op == 6'h2B);
                check("mem_no_write", write, 0);
                tick();
            end
        end
        if (!is_ctl && op != 6'h2B) begin
            mem_ready = 1'($urandom);
            settle();
            check("wb_write", write, 1);
            check("wb_mux", wb_mux_s, op == 6'h23);
            check("wb_rd_mux", rd_mux_s, op == 6'h00);
            tick();
        end

        exp_ret   = (exp_ret + 1) % (1 << CNT_W);
        mem_ready = 1'b0;
        settle();
        check("retired", retired, exp_ret);
        check("after_retire_req", mem_req, !ld);
        if (ld) begin
            check("idle_quiet", {write, pc_write, ir_write}, 0);
            load = 1'b0;
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; load = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        #12;
        check("reset_outputs", all_outs, 0);
        rst_n = 1'b1;
        tick();
        settle();
        check("idle_load_hold", mem_req, 0);
        load = 1'b0;
        tick();

        // ADD with mem_ready on the second FETCH cycle
        do_instr(6'h00, 6'h20, 1'b0, 2, 1, 1'b0);

        // Second ADD interrupted by reset during WB
        mem_ready = 1'b1;
        settle();
        tick();
        mem_ready = 1'b0; opcode = 6'h00; funct = 6'h20;
        tick();
        tick();
        settle();
        check("wb_before_reset", write, 1);
        rst_n = 1'b0;
        #1;
        check("reset_mid_wb", all_outs, 0);
        exp_ret = 0;
        rst_n = 1'b1;
        tick();

        do_instr(6'h23, 6'h00, 1'b0, 1, 3, 1'b0);   // LW, 3-cycle memory wait
        do_instr(6'h2B, 6'h00, 1'b0, 1, 1, 1'b0);   // SW
        do_instr(6'h04, 6'h00, 1'b1, 1, 1, 1'b0);   // BEQ taken
        do_instr(6'h05, 6'h00, 1'b1, 1, 1, 1'b0);   // BNE not taken
        do_instr(6'h08, 6'h00, 1'b0, 3, 1, 1'b0);
        do_instr(6'h0C, 6'h00, 1'b0, 1, 1, 1'b0);
        do_instr(6'h0D, 6'h00, 1'b0, 1, 1, 1'b0);
        do_instr(6'h02, 6'h00, 1'b0, 1, 1, 1'b0);
        do_instr(6'h23, 6'h00, 1'b0, TMO, TMO, 1'b0); // ready on the expiry cycle
        do_instr(6'h08, 6'h00, 1'b0, 1, 1, 1'b1);   // load mid-EXEC
        do_instr(6'h04, 6'h00, 1'b0, 1, 1, 1'b1);

        for (int n = 0; n < 16; n++) begin
            do_instr(legal_ops[$urandom_range(0, 8)], 6'($urandom), 1'($urandom),
                     $urandom_range(1, TMO), $urandom_range(1, TMO), 1'($urandom_range(0, 3) == 0));
        end

        // Illegal opcode traps and ignores load / mem_ready
        do_instr(6'h3F, 6'h00, 1'b0, 1, 1, 1'b0);
        load = 1'b1; mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            settle();
            check("trap_hold", {trap, trap_code}, 3'b101);
            check("trap_quiet", {write, pc_write, ir_write, mem_req}, 0);
        end
        check("trap_retired", retired, exp_ret);

        rst_n = 1'b0;
        #1;
        check("reset_clears_trap", all_outs, 0);
        exp_ret = 0;
        rst_n = 1'b1; load = 1'b0; mem_ready = 1'b0;
        tick();
        for (int k = 0; k < TMO; k++) begin
            settle();
            check("timeout_wait_req", mem_req, 1);
            tick();
        end
        settle();
        check("timeout_trap", {trap, trap_code}, 3'b110);
        check("timeout_req_drop", mem_req, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
